// File: rtl/pixel_stream_gen_pkg.sv
// Shared types and defaults for the raster-scan pixel source.
// State encoding, default widths and the per-pixel tag bundle.
package pixel_stream_pkg;

    localparam int PIX_W_DEF = 24;
    localparam int XW_DEF    = 16;
    localparam int YW_DEF    = 16;
    localparam int AW_DEF    = 20;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [XW_DEF-1:0] x;
        logic [YW_DEF-1:0] y;
        logic              hsync;
        logic              vsync;
        logic              eof;
    } tag_t;

endpackage

// File: rtl/pixel_stream_gen_if.sv
// Valid/ready pixel stream carrying data plus raster tags.
// master drives pixels, slave consumes them.
interface pixel_stream_if
    import pixel_stream_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF
);
    logic             valid;
    logic             ready;
    logic [PIX_W-1:0] data;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             hsync;
    logic             vsync;
    logic             eof;

    modport master (
        output valid, data, x, y, hsync, vsync, eof,
        input  ready
    );

    modport slave (
        input  valid, data, x, y, hsync, vsync, eof,
        output ready
    );
endinterface

// File: rtl/pixel_stream_gen_skid.sv
// Two-entry skid buffer behind a 1-cycle-latency read port.
// Tracks the in-flight read and grants credit while slots remain.
module stream_skid_buffer #(
    parameter int DW = 24,
    parameter int TW = 35
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [TW-1:0] tag_i,
    input  logic [DW-1:0] rdata_i,
    output logic          credit_o,
    output logic          empty_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic [TW-1:0] tag_o
);
    logic             pend_q;
    logic [TW-1:0]    pend_tag_q;
    logic [DW+TW-1:0] slot0_q;
    logic [DW+TW-1:0] slot1_q;
    logic [1:0]       cnt_q;
    logic [DW+TW-1:0] in_w;
    logic [DW+TW-1:0] head;
    logic             pop;

    assign in_w     = {rdata_i, pend_tag_q};
    assign head     = (cnt_q != 2'd0) ? slot0_q : in_w;
    assign valid_o  = (cnt_q != 2'd0) || pend_q;
    assign pop      = valid_o && ready_i;
    assign data_o   = head[DW+TW-1:TW];
    assign tag_o    = head[TW-1:0];
    assign credit_o = (cnt_q + {1'b0, pend_q}) < 2'd2;
    assign empty_o  = (cnt_q == 2'd0) && !pend_q;

    // Track the read in flight; its tag waits for the returning data.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_tag_q <= '0;
        end else begin
            pend_q <= push_i;
            if (push_i) pend_tag_q <= tag_i;
        end
    end

    // Store returning data that cannot leave this cycle; head is slot0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else if (cnt_q == 2'd0) begin
            if (pend_q && !pop) begin
                slot0_q <= in_w;
                cnt_q   <= 2'd1;
            end
        end else if (pop) begin
            slot0_q <= (cnt_q == 2'd2) ? slot1_q : in_w;
            slot1_q <= in_w;
            cnt_q   <= cnt_q - 2'd1 + {1'b0, pend_q};
        end else if (pend_q) begin
            slot1_q <= in_w;
            cnt_q   <= 2'd2;
        end
    end
endmodule

// File: rtl/pixel_stream_gen.sv
// Raster-scan frame-buffer reader emitting a tagged pixel stream.
// PIXEL_STREAM_BOTTOM_UP_EN: read stored rows last-to-first (BMP order).
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int AW    = AW_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [15:0]      num_frames_i,
    input  logic [XW-1:0]    width_i,
    input  logic [YW-1:0]    height_i,
    input  logic [AW-1:0]    stride_i,
    input  logic [AW-1:0]    base_addr_i,
    output logic             mem_rd_o,
    output logic [AW-1:0]    mem_addr_o,
    input  logic [PIX_W-1:0] mem_rdata_i,
    pixel_stream_if.master   out_if,
    output logic [15:0]      frame_o,
    output logic             busy_o
);
    localparam int TW = XW + YW + 3;

`ifdef PIXEL_STREAM_BOTTOM_UP_EN
    localparam bit BOTTOM_UP = 1'b1;
`else
    localparam bit BOTTOM_UP = 1'b0;
`endif

    state_e        state_q;
    logic [XW-1:0] w_q, x_q;
    logic [YW-1:0] h_q, y_q, sc_q;
    logic [AW-1:0] stride_q, base_q, row_q;
    logic [AW-1:0] row_next;
    logic [15:0]   nf_q, fi_q, frame_q;
    logic          start_ok, rd, credit, sb_empty;
    logic          last_x, last_y, more;
    logic [TW-1:0] rd_tag, o_tag;

    assign start_ok = (state_q == IDLE) && start_i &&
                      (width_i != '0) && (height_i != '0);
    assign last_x   = x_q == w_q - XW'(1);
    assign last_y   = y_q == h_q - YW'(1);
    assign more     = (nf_q == 16'd0) || ((fi_q + 16'd1) != nf_q);
    assign rd       = (state_q == RUN) && en_i && credit;
    assign row_next = BOTTOM_UP ? row_q - stride_q : row_q + stride_q;

    assign rd_tag = {x_q, y_q, x_q == '0,
                     (x_q == '0) && (y_q == '0),
                     last_x && last_y};

    assign mem_rd_o   = rd;
    assign mem_addr_o = row_q + AW'(x_q);
    assign frame_o    = frame_q;
    assign busy_o     = (state_q != IDLE) || !sb_empty;

    // Sequencer: config capture, start-row setup and raster scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            stride_q <= '0;
            base_q   <= '0;
            nf_q     <= '0;
            fi_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sc_q     <= '0;
            row_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        w_q      <= width_i;
                        h_q      <= height_i;
                        stride_q <= stride_i;
                        base_q   <= base_addr_i;
                        nf_q     <= num_frames_i;
                        fi_q     <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        row_q    <= base_addr_i;
                        sc_q     <= BOTTOM_UP ? height_i - YW'(1) : '0;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    if (sc_q != '0) begin
                        row_q <= row_q + stride_q;
                        sc_q  <= sc_q - YW'(1);
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (rd) begin
                        if (!last_x) begin
                            x_q <= x_q + XW'(1);
                        end else begin
                            x_q <= '0;
                            if (!last_y) begin
                                y_q   <= y_q + YW'(1);
                                row_q <= row_next;
                            end else begin
                                y_q     <= '0;
                                row_q   <= base_q;
                                sc_q    <= BOTTOM_UP ? h_q - YW'(1) : '0;
                                fi_q    <= fi_q + 16'd1;
                                state_q <= more ? SETUP : DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (sb_empty) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Count frames as their eof pixel is accepted; restart per run.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
        end else if (start_ok) begin
            frame_q <= '0;
        end else if (out_if.valid && out_if.ready && out_if.eof) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    stream_skid_buffer #(
        .DW (PIX_W),
        .TW (TW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push_i   (rd),
        .tag_i    (rd_tag),
        .rdata_i  (mem_rdata_i),
        .credit_o (credit),
        .empty_o  (sb_empty),
        .valid_o  (out_if.valid),
        .ready_i  (out_if.ready),
        .data_o   (out_if.data),
        .tag_o    (o_tag)
    );

    assign out_if.x     = o_tag[TW-1 -: XW];
    assign out_if.y     = o_tag[YW+2:3];
    assign out_if.hsync = o_tag[2];
    assign out_if.vsync = o_tag[1];
    assign out_if.eof   = o_tag[0];
endmodule
